// File: rtl/imem_fetch_arbiter.sv
// Round-robin arbiter sharing one fixed-latency instruction memory between fetch units.
// A tag pipeline follows each read so the word returns to its core; a redirect squashes that core's reads.
module imem_fetch_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [NUM_CORES-1:0]        i_req,
  input  logic [NUM_CORES*ADDR_W-1:0] i_addr,
  input  logic [NUM_CORES-1:0]        i_flush,
  output logic [NUM_CORES-1:0]        o_gnt,
  output logic [NUM_CORES-1:0]        o_rvalid,
  output logic [DATA_W-1:0]           o_rdata,
  output logic                        o_mem_en,
  output logic [ADDR_W-1:0]           o_mem_addr,
  input  logic [DATA_W-1:0]           i_mem_rdata
);

  localparam int unsigned ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [ID_W-1:0]      r_rr_ptr;
  logic [NUM_CORES-1:0] w_cand;
  logic                 w_hit;
  logic [ID_W-1:0]      w_win;

  logic [MEM_LAT-1:0]   r_tag_vld;
  logic [ID_W-1:0]      r_tag_id [MEM_LAT];
  logic [ID_W-1:0]      w_rsp_id;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_CORES) s = s - NUM_CORES;
    return s[ID_W-1:0];
  endfunction

  // A core being redirected this cycle is excluded so its stale address is never issued.
  always_comb begin
    w_cand = i_req & ~i_flush;
    w_hit  = 1'b0;
    w_win  = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (!w_hit && w_cand[wrap_idx(r_rr_ptr, k)]) begin
        w_hit = 1'b1;
        w_win = wrap_idx(r_rr_ptr, k);
      end
    end
  end

  always_comb begin
    o_gnt      = '0;
    o_mem_addr = '0;
    if (w_hit) begin
      o_gnt[w_win] = 1'b1;
      o_mem_addr   = i_addr[w_win*ADDR_W +: ADDR_W];
    end
  end

  assign o_mem_en = w_hit;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_ptr <= '0;
    end else if (w_hit) begin
      r_rr_ptr <= wrap_idx(w_win, 1);
    end
  end

  // Valid bits of a flushed core are dropped as they move to the next stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tag_vld <= '0;
    end else begin
      r_tag_vld[0] <= w_hit;
      for (int unsigned k = 1; k < MEM_LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1] & ~i_flush[r_tag_id[k-1]];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    r_tag_id[0] <= w_win;
    for (int unsigned k = 1; k < MEM_LAT; k++) begin
      r_tag_id[k] <= r_tag_id[k-1];
    end
  end

  assign w_rsp_id = r_tag_id[MEM_LAT-1];

  // The final stage is also gated by this cycle's flush, dropping a response that lands on a redirect.
  always_comb begin
    o_rvalid = '0;
    if (r_tag_vld[MEM_LAT-1] && !i_flush[w_rsp_id]) begin
      o_rvalid[w_rsp_id] = 1'b1;
    end
  end

  assign o_rdata = i_mem_rdata;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed and randomized checks of imem_fetch_arbiter at memory latencies 1, 2 and 3.
// The three instances share stimulus; each has its own ROM stub with the matching delay.
module tb_imem_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, flush;
  logic [31:0] a [4];
  logic [127:0] addr;

  logic [3:0]  gnt1, rv1, gnt2, rv2, gnt3, rv3;
  logic [31:0] rd1, rd2, rd3, maddr1, maddr2, maddr3, mrd1, mrd2, mrd3;
  logic        men1, men2, men3;

  logic [31:0] q1;
  logic [31:0] q2 [2];
  logic [31:0] q3 [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign addr = {a[3], a[2], a[1], a[0]};

  function automatic logic [31:0] romf(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  always @(posedge clk) begin
    q1    <= maddr1;
    q2[0] <= maddr2;
    q2[1] <= q2[0];
    q3[0] <= maddr3;
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign mrd1 = romf(q1);
  assign mrd2 = romf(q2[1]);
  assign mrd3 = romf(q3[2]);

  imem_fetch_arbiter #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_addr(addr), .i_flush(flush),
    .o_gnt(gnt1), .o_rvalid(rv1), .o_rdata(rd1), .o_mem_en(men1),
    .o_mem_addr(maddr1), .i_mem_rdata(mrd1));

  imem_fetch_arbiter #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_lat2 (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_addr(addr), .i_flush(flush),
    .o_gnt(gnt2), .o_rvalid(rv2), .o_rdata(rd2), .o_mem_en(men2),
    .o_mem_addr(maddr2), .i_mem_rdata(mrd2));

  imem_fetch_arbiter #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_lat3 (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_addr(addr), .i_flush(flush),
    .o_gnt(gnt3), .o_rvalid(rv3), .o_rdata(rd3), .o_mem_en(men3),
    .o_mem_addr(maddr3), .i_mem_rdata(mrd3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; flush = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; flush = '0;
    for (int i = 0; i < 4; i++) a[i] = 32'h1000 + 32'(i) * 32'h10;
    tick(); tick();
    sample();
    checks++; if ({rv1, rv2, rv3} !== 12'h000) begin errors++; $display("FAIL rst_rvalid: got %h expected 000", {rv1, rv2, rv3}); end
    checks++; if (gnt1 !== 4'b0000) begin errors++; $display("FAIL rst_gnt_idle: got %b expected 0000", gnt1); end
    checks++; if (men1 !== 1'b0) begin errors++; $display("FAIL rst_mem_en_idle: got %b expected 0", men1); end
    checks++; if (maddr1 !== 32'h0) begin errors++; $display("FAIL rst_mem_addr_idle: got %h expected 0", maddr1); end
    tick();
    req = 4'b0010;
    sample();
    checks++; if (gnt1 !== 4'b0010) begin errors++; $display("FAIL rst_gnt_follow: got %b expected 0010", gnt1); end
    checks++; if (maddr1 !== 32'h1010) begin errors++; $display("FAIL rst_mem_addr_follow: got %h expected 1010", maddr1); end
    tick();
    rst = 1'b0; req = '0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; a[0] = 32'h40;
    sample();
    checks++; if (gnt1 !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", gnt1); end
    checks++; if (maddr1 !== 32'h40) begin errors++; $display("FAIL single_mem_addr: got %h expected 40", maddr1); end
    checks++; if (men1 !== 1'b1) begin errors++; $display("FAIL single_mem_en: got %b expected 1", men1); end
    checks++; if (rv1 !== 4'b0000) begin errors++; $display("FAIL single_rvalid_early: got %b expected 0000", rv1); end
    tick();
    req = 4'b0000;
    sample();
    checks++; if (rv1 !== 4'b0001) begin errors++; $display("FAIL single_rvalid: got %b expected 0001", rv1); end
    checks++; if (rd1 !== romf(32'h40)) begin errors++; $display("FAIL single_rdata: got %h expected %h", rd1, romf(32'h40)); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) a[i] = 32'h100 + 32'(i) * 4;
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      sample();
      exp = 4'b0001 << (c % 4);
      checks++; if (gnt1 !== exp) begin errors++; $display("FAIL rr_gnt c%0d: got %b expected %b", c, gnt1, exp); end
      checks++; if (men1 !== 1'b1) begin errors++; $display("FAIL rr_mem_en c%0d: got %b expected 1", c, men1); end
      checks++; if (maddr1 !== a[c % 4]) begin errors++; $display("FAIL rr_mem_addr c%0d: got %h expected %h", c, maddr1, a[c % 4]); end
      if (c >= 1) begin
        exp = 4'b0001 << ((c - 1) % 4);
        checks++; if (rv1 !== exp) begin errors++; $display("FAIL rr_rvalid1 c%0d: got %b expected %b", c, rv1, exp); end
        checks++; if (rd1 !== romf(a[(c - 1) % 4])) begin errors++; $display("FAIL rr_rdata1 c%0d: got %h expected %h", c, rd1, romf(a[(c - 1) % 4])); end
      end
      if (c >= 3) begin
        exp = 4'b0001 << ((c - 3) % 4);
        checks++; if (rv3 !== exp) begin errors++; $display("FAIL rr_rvalid3 c%0d: got %b expected %b", c, rv3, exp); end
        checks++; if (rd3 !== romf(a[(c - 3) % 4])) begin errors++; $display("FAIL rr_rdata3 c%0d: got %h expected %h", c, rd3, romf(a[(c - 3) % 4])); end
      end
      tick();
    end
    req = 4'b0000;
    sample();
    checks++; if (rv1 !== 4'b1000) begin errors++; $display("FAIL rr_rvalid1_tail: got %b expected 1000", rv1); end
    checks++; if (rv3 !== 4'b0010) begin errors++; $display("FAIL rr_rvalid3_tail: got %b expected 0010", rv3); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    a[1] = 32'h1100; a[2] = 32'h2200;
    req = 4'b0100; flush = 4'b0000;
    sample();
    checks++; if (gnt3 !== 4'b0100) begin errors++; $display("FAIL fl_gnt_t0: got %b expected 0100", gnt3); end
    tick();
    req = 4'b0010; flush = 4'b0100;
    sample();
    checks++; if (gnt3 !== 4'b0010) begin errors++; $display("FAIL fl_gnt_t1: got %b expected 0010", gnt3); end
    checks++; if (rv1 !== 4'b0000) begin errors++; $display("FAIL fl_same_cycle_drop: got %b expected 0000", rv1); end
    tick();
    req = 4'b0100; flush = 4'b0100;
    sample();
    checks++; if (gnt1 !== 4'b0000 || men1 !== 1'b0) begin errors++; $display("FAIL fl_mask_gnt: got %b/%b expected 0000/0", gnt1, men1); end
    checks++; if (rv1 !== 4'b0010) begin errors++; $display("FAIL fl_other_rvalid1: got %b expected 0010", rv1); end
    checks++; if (rd1 !== romf(32'h1100)) begin errors++; $display("FAIL fl_other_rdata1: got %h expected %h", rd1, romf(32'h1100)); end
    checks++; if (rv2 !== 4'b0000) begin errors++; $display("FAIL fl_drop_lat2: got %b expected 0000", rv2); end
    tick();
    req = 4'b0000; flush = 4'b0000;
    sample();
    checks++; if (rv3 !== 4'b0000) begin errors++; $display("FAIL fl_drop_lat3: got %b expected 0000", rv3); end
    checks++; if (rv2 !== 4'b0010) begin errors++; $display("FAIL fl_other_rvalid2: got %b expected 0010", rv2); end
    tick();
    sample();
    checks++; if (rv3 !== 4'b0010) begin errors++; $display("FAIL fl_other_rvalid3: got %b expected 0010", rv3); end
    checks++; if (rd3 !== romf(32'h1100)) begin errors++; $display("FAIL fl_other_rdata3: got %h expected %h", rd3, romf(32'h1100)); end
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 4; i++) a[i] = 32'h500 + 32'(i) * 4;
    req = 4'b1111;
    sample();
    checks++; if (gnt2 !== 4'b0001) begin errors++; $display("FAIL mr_gnt_t0: got %b expected 0001", gnt2); end
    tick();
    rst = 1'b1;
    sample();
    checks++; if (gnt2 !== 4'b0010 || men2 !== 1'b1) begin errors++; $display("FAIL mr_gnt_t1: got %b/%b expected 0010/1", gnt2, men2); end
    checks++; if (rv2 !== 4'b0000) begin errors++; $display("FAIL mr_rvalid_t1: got %b expected 0000", rv2); end
    tick();
    rst = 1'b0;
    sample();
    checks++; if (gnt2 !== 4'b0001) begin errors++; $display("FAIL mr_gnt_t2: got %b expected 0001", gnt2); end
    checks++; if (rv2 !== 4'b0000) begin errors++; $display("FAIL mr_rvalid_t2: got %b expected 0000", rv2); end
    tick();
    req = 4'b0000;
    sample();
    checks++; if (rv2 !== 4'b0000) begin errors++; $display("FAIL mr_rvalid_t3: got %b expected 0000", rv2); end
    tick();
    sample();
    checks++; if (rv2 !== 4'b0001) begin errors++; $display("FAIL mr_rvalid_t4: got %b expected 0001", rv2); end
    checks++; if (rd2 !== romf(a[0])) begin errors++; $display("FAIL mr_rdata_t4: got %h expected %h", rd2, romf(a[0])); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  eg, e1, e3;
    logic [31:0] d1, d3;
    do_reset();
    a[0] = 32'h0A00; a[1] = 32'h0B00; a[3] = 32'h3300;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin req = 4'b0100; a[2] = 32'h200 + 32'(c) * 4; end
      else if (c == 3) req = 4'b1011;
      else if (c == 4) req = 4'b0011;
      else req = 4'b0000;
      eg = (c < 3) ? 4'b0100 : (c == 3) ? 4'b1000 : (c == 4) ? 4'b0001 : 4'b0000;
      e1 = 4'b0000; d1 = '0;
      if (c >= 1 && c <= 3) begin e1 = 4'b0100; d1 = romf(32'h200 + 32'(c - 1) * 4); end
      if (c == 4) begin e1 = 4'b1000; d1 = romf(32'h3300); end
      if (c == 5) begin e1 = 4'b0001; d1 = romf(32'h0A00); end
      e3 = (c >= 3) ? 4'b0100 : 4'b0000;
      d3 = romf(32'h200 + 32'(c - 3) * 4);
      sample();
      checks++; if (gnt1 !== eg) begin errors++; $display("FAIL b2b_gnt c%0d: got %b expected %b", c, gnt1, eg); end
      checks++; if (rv1 !== e1) begin errors++; $display("FAIL b2b_rvalid1 c%0d: got %b expected %b", c, rv1, e1); end
      if (e1 != 4'b0000) begin
        checks++; if (rd1 !== d1) begin errors++; $display("FAIL b2b_rdata1 c%0d: got %h expected %h", c, rd1, d1); end
      end
      checks++; if (rv3 !== e3) begin errors++; $display("FAIL b2b_rvalid3 c%0d: got %b expected %b", c, rv3, e3); end
      if (e3 != 4'b0000) begin
        checks++; if (rd3 !== d3) begin errors++; $display("FAIL b2b_rdata3 c%0d: got %h expected %h", c, rd3, d3); end
      end
      tick();
    end
  endtask

  // Scoreboard indexed by issue cycle; a flush invalidates that core's entries still in flight.
  logic        sv [8];
  logic [1:0]  sc [8];
  logic [31:0] sa [8];
  int          wait_cnt [4];

  task automatic test_random();
    logic [1:0]  m_ptr, w, idx;
    logic        hit, prev_hit;
    logic [1:0]  prev_w;
    logic [3:0]  cand, exp_rv;
    logic [31:0] exp_rd;
    int          s;
    do_reset();
    m_ptr = 2'd0; prev_hit = 1'b0; prev_w = 2'd0;
    for (int i = 0; i < 8; i++) sv[i] = 1'b0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (prev_hit) req[prev_w] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i] = 1'b1;
          a[i] = $urandom & 32'hFFFF_FFFC;
        end
        flush[i] = ($urandom_range(0, 7) == 0);
      end
      for (int i = 0; i < 4; i++) begin
        if (flush[i]) begin
          for (int d = 1; d <= 3; d++) begin
            if (cyc >= d) begin
              s = (cyc - d) % 8;
              if (sv[s] && sc[s] == 2'(i)) sv[s] = 1'b0;
            end
          end
        end
      end
      cand = req & ~flush;
      hit = 1'b0; w = 2'd0;
      for (int k = 0; k < 4; k++) begin
        idx = m_ptr + 2'(k);
        if (!hit && cand[idx]) begin hit = 1'b1; w = idx; end
      end
      exp_rv = 4'b0000; exp_rd = '0;
      if (cyc >= 3 && sv[(cyc - 3) % 8]) begin
        exp_rv[sc[(cyc - 3) % 8]] = 1'b1;
        exp_rd = romf(sa[(cyc - 3) % 8]);
      end
      sv[cyc % 8] = hit; sc[cyc % 8] = w; sa[cyc % 8] = a[w];
      sample();
      checks++; if (gnt3 !== (hit ? (4'b0001 << w) : 4'b0000)) begin errors++; $display("FAIL rnd_gnt cyc%0d: got %b expected %b", cyc, gnt3, hit ? (4'b0001 << w) : 4'b0000); end
      if (hit) begin
        checks++; if (maddr3 !== a[w]) begin errors++; $display("FAIL rnd_mem_addr cyc%0d: got %h expected %h", cyc, maddr3, a[w]); end
      end
      checks++; if (rv3 !== exp_rv) begin errors++; $display("FAIL rnd_rvalid cyc%0d: got %b expected %b", cyc, rv3, exp_rv); end
      if (exp_rv != 4'b0000) begin
        checks++; if (rd3 !== exp_rd) begin errors++; $display("FAIL rnd_rdata cyc%0d: got %h expected %h", cyc, rd3, exp_rd); end
      end
      checks++; if (!$onehot0(gnt1) || !$onehot0(rv1) || !$onehot0(rv2)) begin errors++; $display("FAIL rnd_onehot cyc%0d: got %b/%b/%b expected one-hot or zero", cyc, gnt1, rv1, rv2); end
      for (int i = 0; i < 4; i++) begin
        if (cand[i] && !gnt3[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
      end
      checks++;
      if (wait_cnt[0] > 3 || wait_cnt[1] > 3 || wait_cnt[2] > 3 || wait_cnt[3] > 3) begin
        errors++;
        $display("FAIL rnd_starve cyc%0d: got waits %0d/%0d/%0d/%0d expected at most 3", cyc, wait_cnt[0], wait_cnt[1], wait_cnt[2], wait_cnt[3]);
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      end
      if (hit) m_ptr = w + 2'd1;
      prev_hit = hit; prev_w = w;
      tick();
    end
    req = '0; flush = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; flush = '0;
    for (int i = 0; i < 4; i++) a[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_flush();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
